// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed Booth multiply / restoring divide unit feeding HI/LO
// Divider datapath is present only when MULT_DIV_DIV_EN is defined.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             StartMult,
    input  logic             StartDiv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             MultEnd,
    output logic             DivEnd,
    output logic             DivZero,
    output logic [WIDTH-1:0] HighOut,
    output logic [WIDTH-1:0] LowOut
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t          state;
    state_t          nextState;
    logic [CW-1:0]   count;
    logic            lastIter;
    logic            divGo;

    // Booth state: {acc, multiplier, q-1}
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   prod;
    logic [2*WIDTH:0]   prodNext;
    logic [WIDTH:0]     accExt;
    logic [WIDTH:0]     mcandExt;
    logic [WIDTH:0]     boothSum;

`ifdef MULT_DIV_DIV_EN
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quoNext;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH:0]     shifted;
    logic               fits;
    logic               negQ;
    logic               negR;
    logic               divByZero;

    assign divGo = StartDiv;
`else
    logic unusedStartDiv;

    assign unusedStartDiv = StartDiv;
    assign divGo          = 1'b0;
`endif

    assign lastIter = (count == LAST);
    assign Busy     = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (StartMult) begin
                    nextState = MULT;
                end else if (divGo) begin
                    nextState = DIV;
                end
            end
            MULT: begin
                if (lastIter) begin
                    nextState = DONE;
                end
            end
`ifdef MULT_DIV_DIV_EN
            DIV: begin
                if (divByZero || lastIter) begin
                    nextState = DONE;
                end
            end
`endif
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The add/sub is one bit wider so that A = most-negative cannot overflow the accumulator.
    always_comb begin
        accExt   = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        mcandExt = {mcand[WIDTH-1], mcand};
        case (prod[1:0])
            2'b01:   boothSum = accExt + mcandExt;
            2'b10:   boothSum = accExt - mcandExt;
            default: boothSum = accExt;
        endcase
        prodNext = {boothSum, prod[WIDTH:1]};
    end

`ifdef MULT_DIV_DIV_EN
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        remNext = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
        quoNext = {quo[WIDTH-2:0], fits};
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            mcand     <= '0;
            prod      <= '0;
            HighOut   <= '0;
            LowOut    <= '0;
            MultEnd   <= 1'b0;
            DivEnd    <= 1'b0;
            DivZero   <= 1'b0;
`ifdef MULT_DIV_DIV_EN
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            divByZero <= 1'b0;
`endif
        end else begin
            MultEnd <= 1'b0;
            DivEnd  <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (StartMult) begin
                        mcand <= A;
                        prod  <= {{WIDTH{1'b0}}, B, 1'b0};
                        count <= '0;
                    end
`ifdef MULT_DIV_DIV_EN
                    else if (divGo) begin
                        divisor   <= B[WIDTH-1] ? -B : B;
                        quo       <= A[WIDTH-1] ? -A : A;
                        rem       <= '0;
                        negQ      <= A[WIDTH-1] ^ B[WIDTH-1];
                        negR      <= A[WIDTH-1];
                        divByZero <= (B == '0);
                        count     <= '0;
                    end
`endif
                end
                MULT: begin
                    prod  <= prodNext;
                    count <= count + 1'b1;
                    if (lastIter) begin
                        HighOut <= prodNext[2*WIDTH:WIDTH+1];
                        LowOut  <= prodNext[WIDTH:1];
                        MultEnd <= 1'b1;
                    end
                end
`ifdef MULT_DIV_DIV_EN
                DIV: begin
                    if (divByZero) begin
                        DivEnd  <= 1'b1;
                        DivZero <= 1'b1;
                    end else begin
                        rem   <= remNext;
                        quo   <= quoNext;
                        count <= count + 1'b1;
                        if (lastIter) begin
                            LowOut  <= negQ ? -quoNext : quoNext;
                            HighOut <= negR ? -remNext : remNext;
                            DivEnd  <= 1'b1;
                        end
                    end
                end
`endif
                DONE:    count <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        StartMult;
    logic        StartDiv;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        MultEnd;
    logic        DivEnd;
    logic        DivZero;
    logic [31:0] HighOut;
    logic [31:0] LowOut;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .StartMult(StartMult), .StartDiv(StartDiv),
        .A(A), .B(B), .Busy(Busy), .MultEnd(MultEnd), .DivEnd(DivEnd),
        .DivZero(DivZero), .HighOut(HighOut), .LowOut(LowOut)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          isDiv;
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
        int          edgeNum;
    } exp_t;

    exp_t        expQ[$];
    int          edgeCnt = 0;
    int          tests = 0;
    int          fails = 0;
    bit          endSeen = 0;
    logic [31:0] holdHi = 0, holdLo = 0;
    logic [31:0] modelHi = 0, modelLo = 0;

    always @(posedge clock) edgeCnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per end pulse; between pulses HI/LO must hold.
    exp_t mon;
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            if (MultEnd || DivEnd || DivZero) begin
                endSeen = 1;
                if (expQ.size() == 0) begin
                    check("unexpected_end_pulse", {61'd0, MultEnd, DivEnd, DivZero}, 64'd0);
                end else begin
                    mon = expQ.pop_front();
                    check("mult_end", MultEnd, !mon.isDiv);
                    check("div_end", DivEnd, mon.isDiv);
                    check("div_zero", DivZero, mon.dz);
                    check("high_out", HighOut, mon.hi);
                    check("low_out", LowOut, mon.lo);
                    check("latency_edge", edgeCnt, mon.edgeNum);
                    holdHi = mon.hi;
                    holdLo = mon.lo;
                end
            end else if (Busy) begin
                check("hold_while_busy", {HighOut, LowOut}, {holdHi, holdLo});
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following DONE.
    task automatic doOp(input bit isDiv, input bit both, input logic [31:0] a,
                        input logic [31:0] b, input int noiseAt);
        exp_t   e;
        longint p, q, r;
        A = a;
        B = b;
        StartMult = !isDiv || both;
        StartDiv  = isDiv || both;
        e.isDiv = 0;
        e.dz    = 0;
        if (!isDiv || both) begin
            p       = longint'($signed(a)) * longint'($signed(b));
            e.hi    = p[63:32];
            e.lo    = p[31:0];
            e.edgeNum = edgeCnt + 33;
        end else if (b == 0) begin
            e.isDiv = 1;
            e.dz    = 1;
            e.hi    = modelHi;
            e.lo    = modelLo;
            e.edgeNum = edgeCnt + 2;
        end else begin
            q       = longint'($signed(a)) / longint'($signed(b));
            r       = longint'($signed(a)) % longint'($signed(b));
            e.isDiv = 1;
            e.hi    = r[31:0];
            e.lo    = q[31:0];
            e.edgeNum = edgeCnt + 33;
        end
        modelHi = e.hi;
        modelLo = e.lo;
        expQ.push_back(e);
        endSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            StartMult = (i == noiseAt);
            StartDiv  = (i == noiseAt);
            A = $urandom;
            B = $urandom;
            if (endSeen) break;
        end
        StartMult = 0;
        StartDiv  = 0;
        if (!endSeen) check("end_pulse_timeout", 0, 1);
        @(negedge clock);
        #1;
        check("idle_after_done", Busy, 0);
    endtask

    int          busySeen;
    bit          rndDiv;
    logic [31:0] ra, rb;

    initial begin
        reset = 1; StartMult = 0; StartDiv = 0; A = 0; B = 0;
        repeat (2) @(negedge clock);
        #1 reset = 0;
        check("reset_busy", Busy, 0);
        check("reset_mult_end", MultEnd, 0);
        check("reset_div_end", DivEnd, 0);
        check("reset_div_zero", DivZero, 0);
        check("reset_high", HighOut, 0);
        check("reset_low", LowOut, 0);

        doOp(0, 0, 32'd7, 32'hFFFF_FFFD, -1);
        doOp(0, 0, 32'h8000_0000, 32'h8000_0000, -1);
        doOp(0, 0, 32'h8000_0000, 32'h7FFF_FFFF, -1);
`ifdef MULT_DIV_DIV_EN
        doOp(1, 0, 32'hFFFF_FFF9, 32'd2, -1);
        doOp(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        doOp(1, 0, 32'd95, 32'd10, -1);
        doOp(1, 0, 32'd1234, 32'd0, -1);
        doOp(1, 0, 32'd7, 32'hFFFF_FFFE, -1);
`else
        StartDiv = 1; A = 32'd100; B = 32'd3;
        @(negedge clock);
        #1 StartDiv = 0;
        busySeen = 0;
        repeat (40) begin
            @(negedge clock);
            if (Busy) busySeen = 1;
        end
        #1;
        check("start_div_ignored", busySeen, 0);
`endif
        doOp(0, 1, 32'd3, 32'd4, 10);

        doOp(0, 0, 32'd5, 32'd6, -1);
        StartMult = 1; A = $urandom; B = $urandom;
        @(negedge clock);
        #1 StartMult = 0;
        repeat (10) @(negedge clock);
        #2 reset = 1;
        #1;
        check("midop_reset_busy", Busy, 0);
        check("midop_reset_high", HighOut, 0);
        check("midop_reset_low", LowOut, 0);
        check("midop_reset_ends", {MultEnd, DivEnd, DivZero}, 0);
        expQ.delete();
        holdHi = 0; holdLo = 0; modelHi = 0; modelLo = 0;
        @(negedge clock);
        #1 reset = 0;
        repeat (40) @(negedge clock);
        #1;

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 6 == 0) ra = 32'h8000_0000;
            if (n % 5 == 1) rb = $urandom_range(1, 20);
`ifdef MULT_DIV_DIV_EN
            rndDiv = $urandom_range(0, 1);
            if (rndDiv && n % 7 == 3) rb = 0;
`else
            rndDiv = 0;
`endif
            doOp(rndDiv, 0, ra, rb, $urandom_range(0, 36));
        end

        check("queue_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
